// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver/transmitter state encoding and the
// bus I/O address map used by the bus interface decode.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } spart_state_t;

    // ioaddr decode values
    localparam logic [1:0] RXTX   = 2'b00;
    localparam logic [1:0] STATUS = 2'b01;
    localparam logic [1:0] DB_LO  = 2'b10;
    localparam logic [1:0] DB_HI  = 2'b11;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs. The reset value
// is a parameter so idle-high lines (e.g. rxd) do not glitch on reset release.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // first stage may go metastable; second stage gives it a cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= RST_VAL;
            q       <= RST_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled async serial deserialiser (1 start, LSB
// first data, 1 stop, no parity) with receive-data-available and sticky
// framing/overrun flags for the bus interface.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rxd,
    input  logic                 clr_rda,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 ferr,
    output logic                 ovr
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    spart_state_t         state;
    spart_state_t         state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxd_s;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 stop_smp;
    logic                 stop_good;
    logic                 stop_bad;

    // rxd is asynchronous; idle-high reset value avoids a false start after reset
    sync2 #(
        .RST_VAL (1'b1)
    ) u_rxd_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and sampling strobes; every transition also clears the counter
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !rxd_s) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                // centre of the start bit: a high line here is a glitch, not a frame
                if (enable && cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (enable && cnt == FULL_M1) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (enable && cnt == FULL_M1) begin
                    stop_smp  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    assign stop_good = stop_smp &  rxd_s;
    assign stop_bad  = stop_smp & ~rxd_s;

    // oversample tick counter; parked at zero while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (enable && state != IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // data bit index; wraps to zero after the last data bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
        end
    end

    // LSB arrives first, so shift in at the top and move toward bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

    // bus-visible results; a completion in the same cycle as clr_rda wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= '0;
            rda     <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else if (stop_good) begin
            rx_data <= shreg;
            rda     <= 1'b1;
            ovr     <= clr_rda ? 1'b0 : (ovr | rda);
            ferr    <= clr_rda ? 1'b0 : ferr;
        end else if (stop_bad) begin
            ferr <= 1'b1;
            if (clr_rda) begin
                rda <= 1'b0;
                ovr <= 1'b0;
            end
        end else if (clr_rda) begin
            rda  <= 1'b0;
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end
    end

endmodule
